// File: rtl/tetris_drop_ctrl.sv
// Game sequencer for an 8x8 falling-row Tetris board: spawn, gravity, moves,
// locking, row clearing and game-over detection, with a registered board view.
module tetris_drop_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rstBtn,
  input  logic        start,
  input  logic        stopBtn,
  input  logic [7:0]  piece_mask,
  input  logic        move_left,
  input  logic        move_right,
  output logic        rLED,
  output logic        doneLED,
  output logic [7:0]  lines_cleared,
  output logic [63:0] outputStream
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SPAWN, FALL, LOCK, CLEAR, OVER} state_t;

  state_t        state_q, state_d;
  logic [63:0]   board_q, board_d;
  logic [7:0]    piece_q, piece_d;
  logic [2:0]    row_q, row_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    lines_q, lines_d;
  logic          left_prev_q, left_prev_d;
  logic          right_prev_q, right_prev_d;
  logic [63:0]   out_q, out_d;

  logic        running;
  logic        left_edge, right_edge;
  logic [2:0]  row_plus1;
  logic [7:0]  cur_row, below_row, spawn_piece;
  logic [63:0] piece_at_row;
  logic        full_found;
  logic [2:0]  full_idx;
  logic [63:0] cleared_board;

  assign running      = (state_q == SPAWN) || (state_q == FALL) ||
                        (state_q == LOCK)  || (state_q == CLEAR);
  assign left_edge    = move_left  & ~left_prev_q;
  assign right_edge   = move_right & ~right_prev_q;
  assign row_plus1    = row_q + 3'd1;
  assign cur_row      = board_q[{row_q, 3'b000} +: 8];
  assign below_row    = board_q[{row_plus1, 3'b000} +: 8];
  assign spawn_piece  = (piece_mask != 8'h00) ? piece_mask : 8'h18;
  assign piece_at_row = {56'd0, piece_q} << {row_q, 3'b000};

  // Lowest full row wins; everything above it slides down one row.
  always_comb begin
    full_found    = 1'b0;
    full_idx      = 3'd0;
    for (int r = 0; r < 8; r++) begin
      if (board_q[8*r +: 8] == 8'hFF) begin
        full_found = 1'b1;
        full_idx   = 3'(r);
      end
    end
    cleared_board = board_q;
    for (int r = 1; r < 8; r++) begin
      if (3'(r) <= full_idx) cleared_board[8*r +: 8] = board_q[8*(r-1) +: 8];
    end
    cleared_board[7:0] = 8'h00;
  end

  always_ff @(posedge clk or negedge rstBtn) begin
    if (!rstBtn) begin
      state_q      <= IDLE;
      board_q      <= '0;
      piece_q      <= '0;
      row_q        <= '0;
      tick_q       <= '0;
      lines_q      <= '0;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      piece_q      <= piece_d;
      row_q        <= row_d;
      tick_q       <= tick_d;
      lines_q      <= lines_d;
      left_prev_q  <= left_prev_d;
      right_prev_q <= right_prev_d;
      out_q        <= out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    piece_d      = piece_q;
    row_d        = row_q;
    tick_d       = tick_q;
    lines_d      = lines_q;
    left_prev_d  = move_left;
    right_prev_d = move_right;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          board_d = '0;
          lines_d = '0;
          state_d = SPAWN;
        end
      end
      SPAWN: begin
        row_d  = 3'd0;
        tick_d = '0;
        if ((spawn_piece & board_q[7:0]) != 8'h00) begin
          piece_d = 8'h00;
          state_d = OVER;
        end else begin
          piece_d = spawn_piece;
          state_d = FALL;
        end
      end
      FALL: begin
        // Gravity cycle swallows any move edge arriving in the same cycle.
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if ((row_q == 3'd7) || ((piece_q & below_row) != 8'h00)) state_d = LOCK;
          else row_d = row_plus1;
        end else begin
          tick_d = tick_q + TW'(1);
          if (left_edge && !right_edge) begin
            if (!piece_q[0] && (((piece_q >> 1) & cur_row) == 8'h00)) piece_d = piece_q >> 1;
          end else if (right_edge && !left_edge) begin
            if (!piece_q[7] && (((piece_q << 1) & cur_row) == 8'h00)) piece_d = piece_q << 1;
          end
        end
      end
      LOCK: begin
        board_d = board_q | piece_at_row;
        piece_d = 8'h00;
        state_d = CLEAR;
      end
      CLEAR: begin
        if (full_found) begin
          board_d = cleared_board;
          if (lines_q != 8'hFF) lines_d = lines_q + 8'd1;
        end else begin
          state_d = SPAWN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stopBtn && running) begin
      state_d = IDLE;
      piece_d = 8'h00;
      board_d = board_q;
      lines_d = lines_q;
      row_d   = row_q;
      tick_d  = tick_q;
    end
  end

  always_comb begin
    out_d   = (state_q == FALL) ? (board_q | piece_at_row) : board_q;
    rLED    = running;
    doneLED = (state_q == OVER);
  end

  assign outputStream  = out_q;
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_tetris_drop_ctrl.sv
// Self-checking bench for tetris_drop_ctrl: directed game scenarios followed by
// random play, every cycle compared against a row-array model of the game rules.
module tb_tetris_drop_ctrl;

  localparam int TICK_DIV = 4;
  localparam int M_IDLE = 10, M_SPAWN = 11, M_FALL = 12, M_LOCK = 13, M_CLEAR = 14, M_OVER = 15;

  logic        clk = 1'b0;
  logic        rstBtn = 1'b0;
  logic        start = 1'b0;
  logic        stopBtn = 1'b0;
  logic [7:0]  piece_mask = 8'h00;
  logic        move_left = 1'b0;
  logic        move_right = 1'b0;
  logic        rLED, doneLED;
  logic [7:0]  lines_cleared;
  logic [63:0] outputStream;

  int compared = 0;
  int mismatched = 0;

  // Reference game state: one byte per board row plus the falling piece.
  logic [7:0]  rows [8];
  logic [7:0]  mPiece;
  int          mRow, mTick, mLines, mMode;
  bit          mPrevL, mPrevR;
  logic [63:0] mOut;

  tetris_drop_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rstBtn(rstBtn), .start(start), .stopBtn(stopBtn),
    .piece_mask(piece_mask), .move_left(move_left), .move_right(move_right),
    .rLED(rLED), .doneLED(doneLED), .lines_cleared(lines_cleared),
    .outputStream(outputStream)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] boardView(input bit withPiece);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) begin
      v[8*r +: 8] = rows[r];
      if (withPiece && r == mRow) v[8*r +: 8] = rows[r] | mPiece;
    end
    return v;
  endfunction

  function automatic bit modelRunning();
    return (mMode == M_SPAWN) || (mMode == M_FALL) || (mMode == M_LOCK) || (mMode == M_CLEAR);
  endfunction

  task automatic modelReset();
    for (int r = 0; r < 8; r++) rows[r] = 8'h00;
    mPiece = 8'h00; mRow = 0; mTick = 0; mLines = 0; mMode = M_IDLE;
    mPrevL = 1'b0; mPrevR = 1'b0; mOut = '0;
  endtask

  // Advances the game rules by one clock using the inputs about to be sampled.
  task automatic modelStep(input bit st, input bit sp, input bit ml, input bit mr, input logic [7:0] mask);
    bit le, re;
    int full;
    logic [7:0] p;
    mOut = boardView(mMode == M_FALL);
    le = ml && !mPrevL;
    re = mr && !mPrevR;
    mPrevL = ml;
    mPrevR = mr;
    if (sp && modelRunning()) begin
      mMode = M_IDLE;
      mPiece = 8'h00;
      return;
    end
    case (mMode)
      M_IDLE, M_OVER: begin
        if (st) begin
          for (int r = 0; r < 8; r++) rows[r] = 8'h00;
          mLines = 0;
          mMode = M_SPAWN;
        end
      end
      M_SPAWN: begin
        p = (mask == 8'h00) ? 8'h18 : mask;
        mRow = 0;
        mTick = 0;
        if ((p & rows[0]) != 0) begin mMode = M_OVER; mPiece = 8'h00; end
        else begin mMode = M_FALL; mPiece = p; end
      end
      M_FALL: begin
        if (mTick == TICK_DIV - 1) begin
          mTick = 0;
          if (mRow == 7 || (mPiece & rows[mRow+1]) != 0) mMode = M_LOCK;
          else mRow++;
        end else begin
          mTick++;
          if (le && !re && mPiece[0] == 1'b0 && ((mPiece >> 1) & rows[mRow]) == 0) mPiece = mPiece >> 1;
          if (re && !le && mPiece[7] == 1'b0 && ((mPiece << 1) & rows[mRow]) == 0) mPiece = mPiece << 1;
        end
      end
      M_LOCK: begin
        rows[mRow] = rows[mRow] | mPiece;
        mPiece = 8'h00;
        mMode = M_CLEAR;
      end
      M_CLEAR: begin
        full = -1;
        for (int r = 0; r < 8; r++) if (rows[r] == 8'hFF) full = r;
        if (full >= 0) begin
          for (int r = full; r > 0; r--) rows[r] = rows[r-1];
          rows[0] = 8'h00;
          if (mLines < 255) mLines++;
        end else begin
          mMode = M_SPAWN;
        end
      end
      default: mMode = M_IDLE;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("stream", outputStream, mOut);
    checkOutput("rLED", {63'd0, rLED}, {63'd0, modelRunning()});
    checkOutput("doneLED", {63'd0, doneLED}, {63'd0, mMode == M_OVER});
    checkOutput("lines", {56'd0, lines_cleared}, 64'(mLines));
  endtask

  // Drives one cycle of inputs, steps the model, then checks after the edge.
  task automatic applyStimulus(input bit st, input bit sp, input bit ml, input bit mr, input logic [7:0] mask);
    start = st; stopBtn = sp; move_left = ml; move_right = mr; piece_mask = mask;
    modelStep(st, sp, ml, mr, mask);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Asserts reset between edges so the clear is seen without a clock.
  task automatic doReset();
    rstBtn = 1'b0;
    start = 1'b0; stopBtn = 1'b0; move_left = 1'b0; move_right = 1'b0;
    #2;
    modelReset();
    checkAll();
    @(posedge clk);
    #1;
    rstBtn = 1'b1;
  endtask

  task automatic idleSteps(input int n, input logic [7:0] mask);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, mask);
  endtask

  initial begin
    bit reached;
    $display("[TB] starting tetris_drop_ctrl bench");
    modelReset();
    #1;
    doReset();

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);
    idleSteps(2, 8'h0F);
    checkOutput("first_spawn_view", outputStream, 64'h0F);
    checkOutput("first_rLED", {63'd0, rLED}, 64'd1);
    idleSteps(4, 8'h0F);
    checkOutput("first_gravity", outputStream, 64'h0F00);
    idleSteps(80, 8'hF0);
    checkOutput("row_cleared_count", {56'd0, lines_cleared}, 64'd1);

    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
    idleSteps(1, 8'h80);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h80);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
    checkOutput("move_left_view", outputStream, 64'h40);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h80);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);

    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    reached = 1'b0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
      if (mMode == M_OVER) reached = 1'b1;
    end
    if (!reached) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL over_timeout observed=not_reached expected=OVER");
    end
    checkOutput("over_doneLED", {63'd0, doneLED}, 64'd1);
    checkOutput("over_rLED", {63'd0, rLED}, 64'd0);
    checkOutput("over_column", outputStream, 64'h0101010101010101);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    idleSteps(1, 8'h01);
    checkOutput("restart_clear", outputStream, 64'h0);

    idleSteps(45, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    idleSteps(1, 8'h01);
    checkOutput("stop_rLED", {63'd0, rLED}, 64'd0);
    checkOutput("stop_view", outputStream, 64'h0100000000000000);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
    idleSteps(10, 8'h22);
    doReset();

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idleSteps(2, 8'h00);
    checkOutput("default_piece", outputStream, 64'h18);

    for (int i = 0; i < 1500; i++) begin
      logic [7:0] m;
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 255) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
